// File: rtl/nexys_starship_damage_sched_if.sv
// Signal bundle between the game controller and the damage scheduler.
// The master drives game controls and station status; the slave answers with break commands and state flags.
interface nexys_starship_damage_sched_if;
  logic       play_flag;
  logic       gameover_ctrl;
  logic       timer_tick;
  logic [3:0] broken;
  logic [3:0] break_req;
  logic [3:0] random_hex;
  logic [2:0] level;
  logic       all_broken;
  logic       q_Idle;
  logic       q_Run;
  logic       q_Issue;

  modport master (
    output play_flag, gameover_ctrl, timer_tick, broken,
    input  break_req, random_hex, level, all_broken, q_Idle, q_Run, q_Issue
  );

  modport slave (
    input  play_flag, gameover_ctrl, timer_tick, broken,
    output break_req, random_hex, level, all_broken, q_Idle, q_Run, q_Issue
  );
endinterface

// File: rtl/nexys_starship_damage_sched.sv
// Damage scheduler: picks when and which starship station breaks, plus its repair combo.
// Define STARSHIP_LEVEL_RAMP_EN to build the level counter and the shrinking break interval.
//
// state   | meaning
// S_IDLE  | waiting for play_flag; counters, level and combo cleared
// S_RUN   | counting down timer ticks to the next break
// S_ISSUE | one-cycle break_req pulse, then reload countdown
module nexys_starship_damage_sched #(
  parameter logic [3:0] INTERVAL_INIT = 4'd8,
  parameter logic [3:0] INTERVAL_MIN  = 4'd2,
  parameter logic [7:0] LEVEL_TICKS   = 8'd32,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input logic Clk,
  input logic Reset,
  nexys_starship_damage_sched_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_RUN   = 3'b010,
    S_ISSUE = 3'b100
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_countdown;
  logic [3:0] r_break_req;
  logic [3:0] r_random_hex;
  logic [7:0] r_lfsr;
  logic [3:0] w_interval;
  logic [3:0] w_target;
  logic [2:0] w_level;
  logic       w_lfsr_fb;

  assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

`ifdef STARSHIP_LEVEL_RAMP_EN
  logic [7:0] r_tick_cnt;
  logic [2:0] r_level;
  logic [4:0] w_level_sum;

  // 5-bit sum keeps the floor test from wrapping when level exceeds INTERVAL_INIT
  assign w_level_sum = {2'b00, r_level} + {1'b0, INTERVAL_MIN};
  assign w_interval  = (w_level_sum >= {1'b0, INTERVAL_INIT}) ? INTERVAL_MIN
                                                               : INTERVAL_INIT - {1'b0, r_level};
  assign w_level     = r_level;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_tick_cnt <= 8'd0;
      r_level    <= 3'd0;
    end else if (w_state_next == S_IDLE) begin
      r_tick_cnt <= 8'd0;
      r_level    <= 3'd0;
    end else if (bus.timer_tick && (r_state != S_IDLE)) begin
      if (r_tick_cnt == LEVEL_TICKS - 8'd1) begin
        r_tick_cnt <= 8'd0;
        if (r_level != 3'd7) r_level <= r_level + 3'd1;
      end else begin
        r_tick_cnt <= r_tick_cnt + 8'd1;
      end
    end
  end
`else
  assign w_interval = INTERVAL_INIT;
  assign w_level    = 3'd0;
`endif

  // First free station scanning upward from lfsr[1:0]; lowest offset wins.
  always_comb begin
    logic [1:0] idx;
    idx      = 2'd0;
    w_target = 4'b0000;
    for (int k = 3; k >= 0; k--) begin
      idx = r_lfsr[1:0] + k[1:0];
      if (!bus.broken[idx]) w_target = 4'b0001 << idx;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.play_flag) w_state_next = S_RUN;
      S_RUN: begin
        if (bus.gameover_ctrl)                                w_state_next = S_IDLE;
        else if ((r_countdown == 4'd0) && (bus.broken != 4'hF)) w_state_next = S_ISSUE;
      end
      S_ISSUE: w_state_next = bus.gameover_ctrl ? S_IDLE : S_RUN;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_countdown  <= 4'd0;
      r_break_req  <= 4'd0;
      r_random_hex <= 4'd0;
      r_lfsr       <= LFSR_SEED;
    end else begin
      r_lfsr      <= {r_lfsr[6:0], w_lfsr_fb};
      r_break_req <= 4'd0;
      if (w_state_next == S_IDLE) begin
        r_countdown  <= 4'd0;
        r_random_hex <= 4'd0;
      end else if (r_state == S_IDLE) begin
        r_countdown <= INTERVAL_INIT;
      end else if (r_state == S_ISSUE) begin
        r_countdown <= w_interval;
      end else begin
        if (w_state_next == S_ISSUE) begin
          r_break_req  <= w_target;
          r_random_hex <= r_lfsr[7:4];
        end
        if (bus.timer_tick && (r_countdown != 4'd0)) r_countdown <= r_countdown - 4'd1;
      end
    end
  end

  assign bus.break_req  = r_break_req;
  assign bus.random_hex = r_random_hex;
  assign bus.level      = w_level;
  assign bus.all_broken = (r_state == S_RUN) && (bus.broken == 4'hF);
  assign bus.q_Idle     = (r_state == S_IDLE);
  assign bus.q_Run      = (r_state == S_RUN);
  assign bus.q_Issue    = (r_state == S_ISSUE);

endmodule

// File: tb/tb_nexys_starship_damage_sched.sv
// Bench for nexys_starship_damage_sched: a behavioural game model predicts every cycle,
// a negedge monitor pops the predictions and compares them with the DUT.
`timescale 1ns/1ps
module tb_nexys_starship_damage_sched;
  localparam int         INIT   = 8;
  localparam int         IMIN   = 2;
  localparam int         LTICKS = 32;
  localparam logic [7:0] SEED   = 8'hA5;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  nexys_starship_damage_sched_if bif();

  nexys_starship_damage_sched #(
    .INTERVAL_INIT(4'd8),
    .INTERVAL_MIN (4'd2),
    .LEVEL_TICKS  (8'd32),
    .LFSR_SEED    (SEED)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bif)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int         cyc;
    logic [3:0] req;
    logic [3:0] hex;
    logic [2:0] st;
    logic [2:0] lvl;
    logic       allb;
  } status_t;

  typedef struct {
    int         cyc;
    logic [3:0] req;
    logic [3:0] hex;
  } brk_t;

  status_t stat_q[$];
  brk_t    brk_q[$];
  int      n_cmp = 0;
  int      n_bad = 0;
  int      cyc   = 0;

  // behavioural game model
  bit         m_run, m_issue;
  int         m_cd, m_ticks;
  logic [7:0] m_lfsr;
  logic [3:0] m_req, m_hex;
  logic [3:0] b_var;

  task automatic check(input string name, input int act, input int exp, input int at);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, at, act, exp);
    end
  endtask

  function automatic int m_level();
`ifdef STARSHIP_LEVEL_RAMP_EN
    return (m_ticks / LTICKS > 7) ? 7 : m_ticks / LTICKS;
`else
    return 0;
`endif
  endfunction

  function automatic int m_interval();
    int lv = m_level();
    return (INIT - lv < IMIN) ? IMIN : INIT - lv;
  endfunction

  function automatic logic [3:0] pick(input logic [3:0] b, input int start);
    for (int k = 0; k < 4; k++) begin
      int idx = (start + k) % 4;
      if (!b[idx]) return 4'(1 << idx);
    end
    return 4'd0;
  endfunction

  task automatic go_idle();
    m_run = 0; m_issue = 0; m_cd = 0; m_ticks = 0; m_hex = 4'd0; m_req = 4'd0;
  endtask

  task automatic model_step(input bit p, input bit g, input bit t, input logic [3:0] b);
    logic [7:0] pre;
    brk_t       e;
    pre    = m_lfsr;
    m_lfsr = {pre[6:0], pre[7] ^ pre[5] ^ pre[4] ^ pre[3]};
    if (m_issue) begin
      m_issue = 0;
      m_req   = 4'd0;
      if (g) go_idle();
      else begin
        m_run = 1;
        m_cd  = m_interval();
        if (t) m_ticks++;
      end
    end else if (m_run) begin
      if (g) go_idle();
      else begin
        if (m_cd == 0 && b != 4'hF) begin
          m_run   = 0;
          m_issue = 1;
          m_req   = pick(b, int'(pre[1:0]));
          m_hex   = pre[7:4];
          e.cyc = cyc + 1; e.req = m_req; e.hex = m_hex;
          brk_q.push_back(e);
        end
        if (t) begin
          if (m_cd > 0) m_cd--;
          m_ticks++;
        end
      end
    end else if (p) begin
      m_run = 1;
      m_cd  = INIT;
    end
  endtask

  task automatic push_status(input logic [3:0] b);
    status_t s;
    s.cyc  = cyc;
    s.req  = m_req;
    s.hex  = m_hex;
    s.st   = {m_issue, m_run, !(m_run || m_issue)};
    s.lvl  = 3'(m_level());
    s.allb = m_run && (b == 4'hF);
    stat_q.push_back(s);
  endtask

  // called at posedge+1; drives one clock's worth of inputs
  task automatic cycle(input bit p, input bit g, input bit t, input logic [3:0] b);
    bif.play_flag     = p;
    bif.gameover_ctrl = g;
    bif.timer_tick    = t;
    bif.broken        = b;
    push_status(b);
    model_step(p, g, t, b);
    cyc++;
    @(posedge Clk); #1;
  endtask

  task automatic do_reset(input int n);
    Reset = 1'b1;
    bif.play_flag = 0; bif.gameover_ctrl = 0; bif.timer_tick = 0; bif.broken = 4'd0;
    go_idle();
    m_lfsr = SEED;
    brk_q.delete();
    #1;
    check("rst_break_req", int'(bif.break_req), 0, cyc);
    check("rst_q_idle", int'(bif.q_Idle), 1, cyc);
    for (int i = 0; i < n; i++) begin
      push_status(4'd0);
      cyc++;
      @(posedge Clk); #1;
    end
    Reset = 1'b0;
  endtask

  always @(negedge Clk) begin : monitor
    status_t e;
    brk_t    be;
    if (stat_q.size() > 0) begin
      e = stat_q.pop_front();
      check("state", int'({bif.q_Issue, bif.q_Run, bif.q_Idle}), int'(e.st), e.cyc);
      check("level", int'(bif.level), int'(e.lvl), e.cyc);
      check("all_broken", int'(bif.all_broken), int'(e.allb), e.cyc);
      check("break_req", int'(bif.break_req), int'(e.req), e.cyc);
      check("random_hex", int'(bif.random_hex), int'(e.hex), e.cyc);
      if (bif.break_req != 4'd0) begin
        if (brk_q.size() == 0) begin
          check("unexpected_break", int'(bif.break_req), 0, e.cyc);
        end else begin
          be = brk_q.pop_front();
          check("break_cycle", e.cyc, be.cyc, e.cyc);
          check("break_target", int'(bif.break_req), int'(be.req), e.cyc);
          check("break_hex", int'(bif.random_hex), int'(be.hex), e.cyc);
        end
      end
    end
  end

  initial begin : driver
    int reached;
    bif.play_flag = 0; bif.gameover_ctrl = 0; bif.timer_tick = 0; bif.broken = 4'd0;
    go_idle();
    m_lfsr = SEED;
    @(posedge Clk); #1;
    do_reset(2);

    // first break with only the down station free
    cycle(1, 0, 0, 4'b0111);
    for (int i = 0; i < 14; i++) cycle(0, 0, 1, 4'b0111);

    // randomized play
    b_var = 4'd0;
    for (int i = 0; i < 1500; i++) begin
      if (m_issue) b_var = b_var | m_req;
      if ($urandom_range(0, 5) == 0) b_var[$urandom_range(0, 3)] = 1'b0;
      if ($urandom_range(0, 40) == 0) b_var = 4'b1000;
      if ($urandom_range(0, 60) == 0) b_var = 4'hF;
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1, b_var);
    end

    // all stations broken at expiry, then release the up station
    cycle(0, 1, 0, 4'd0);
    cycle(0, 0, 0, 4'd0);
    cycle(1, 0, 0, 4'hF);
    reached = 0;
    for (int i = 0; i < 40 && !reached; i++) begin
      if (m_run && m_cd == 0) reached = 1;
      else cycle(0, 0, 1, 4'hF);
    end
    check("reach_expiry", reached, 1, cyc);
    for (int i = 0; i < 20; i++) cycle(0, 0, $urandom_range(0, 1) == 1, 4'hF);
    cycle(0, 0, 0, 4'b1011);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 4'b1111);

    // level ramp: continuous ticks, stations repaired immediately
    cycle(0, 1, 0, 4'd0);
    cycle(1, 0, 0, 4'd0);
    for (int i = 0; i < 340; i++) cycle(0, 0, 1, 4'd0);

    // game over while countdown is 3
    cycle(0, 1, 0, 4'd0);
    cycle(1, 0, 0, 4'd0);
    reached = 0;
    for (int i = 0; i < 20 && !reached; i++) begin
      if (m_run && m_cd == 3) reached = 1;
      else cycle(0, 0, 1, 4'd0);
    end
    check("reach_cd3", reached, 1, cyc);
    cycle(0, 1, 1, 4'd0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 4'd0);

    // reset while a break pulse is on the wire
    cycle(1, 0, 0, 4'd0);
    reached = 0;
    for (int i = 0; i < 30 && !reached; i++) begin
      if (m_issue) reached = 1;
      else cycle(0, 0, 1, 4'b0010);
    end
    check("reach_issue", reached, 1, cyc);
    check("pre_rst_q_issue", int'(bif.q_Issue), 1, cyc);
    do_reset(2);

    // recovery after reset
    for (int i = 0; i < 200; i++)
      cycle($urandom_range(0, 9) == 0, 0, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 14)));

    cycle(0, 1, 0, 4'd0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 4'd0);
    @(negedge Clk); #1;
    check("pending_breaks", brk_q.size(), 0, cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nexys_starship_damage_sched.md
# nexys_starship_damage_sched

Damage scheduler for Nexys Starship. It decides when the next starship station breaks and which one, and supplies the 4-bit repair combo for it. One-cycle break requests replace the per-station random strobes and feed the four station controllers (right, left, up, down) plus their `random_hex` inputs. The break interval shortens as the game level rises.

## Interface
- `INTERVAL_INIT`, 8: break interval in timer ticks at level 0; range 1..15.
- `INTERVAL_MIN`, 2: interval floor; range 1..`INTERVAL_INIT`.
- `LEVEL_TICKS`, 32: timer ticks per level step; range 2..255.
- `LFSR_SEED`, 8'hA5: LFSR reset value; must be non-zero.
- `Clk` in 1: system clock.
- `Reset` in 1: asynchronous, active-high reset.
- `play_flag` in 1: game start request.
- `gameover_ctrl` in 1: game over; forces idle.
- `timer_tick` in 1: one-`Clk`-cycle pulse per game tick, synchronous to `Clk`.
- `broken` in 4: station broken status. Bit 0 right, 1 left, 2 up, 3 down.
- `break_req` out 4: one-hot, single-cycle break command. Same bit order as `broken`.
- `random_hex` out 4: repair combo for the latest `break_req`. Held until the next issue.
- `level` out 3: current difficulty, 0..7.
- `all_broken` out 1: high in RUN while `broken == 4'hF`; combinational.
- `q_Idle`, `q_Run`, `q_Issue` out 1 each: one-hot state flags.

## Operation
- **State register:** 3-bit one-hot, {ISSUE, RUN, IDLE}.
- **IDLE**
  - `countdown`, tick counter, `level` and `random_hex` are cleared.
  - If `play_flag`, load `countdown` = `INTERVAL_INIT` and go to RUN.
- **RUN**
  - On `timer_tick`, `countdown` decrements, saturating at 0.
  - If `countdown == 0` and `broken != 4'hF`, go to ISSUE.
  - If `countdown == 0` and all stations are broken, stay in RUN (`all_broken = 1`) until any bit clears.
- **ISSUE (one cycle)**
  - On entry, the register edge latches `break_req` and `random_hex`.
  - `break_req`: the first index i, scanning start, start+1, … mod 4, with `broken[i] == 0`. Both `start = lfsr[1:0]` and `broken` are sampled at that edge.
  - `random_hex` = `lfsr[7:4]`.
  - Next edge: `break_req` returns to 0, `countdown` loads the current interval, and the state goes to RUN.
- **Game over:** `gameover_ctrl` in RUN or ISSUE forces IDLE on the next edge and has priority over all other transitions. A `break_req` pulse already high completes its cycle.
- **LFSR:** 8-bit Fibonacci, advances every `Clk` cycle in all states.
  - Feedback = `l[7]^l[5]^l[4]^l[3]`, shifted left into bit 0.
  - Never all-zero.
- **Level:**
  - An 8-bit tick counter counts `timer_tick` in RUN and ISSUE.
  - At `LEVEL_TICKS-1` it wraps to 0 and `level` increments, saturating at 7.
- **Interval:** `INTERVAL_MIN` if `level + INTERVAL_MIN >= INTERVAL_INIT`, else `INTERVAL_INIT - level`.
  - Compare at 5 bits so it cannot underflow.
  - The interval is evaluated at the ISSUE reload, not mid-count.

## Timing
- **Reset values:** IDLE (`q_Idle = 1`), `break_req = 0`, `random_hex = 0`, `level = 0`, `all_broken = 0`, LFSR = `LFSR_SEED`, `countdown = 0`.
- **Break latency:**
  - The `timer_tick` that takes `countdown` 1→0 is sampled at edge N.
  - ISSUE is entered at edge N+1, and `break_req` is high from N+1 to N+2.
  - Countdown restarts after edge N+2.
- **Start:** `play_flag` sampled at edge M puts the state in RUN after M. The first break requires `INTERVAL_INIT` ticks.
- **All-broken release:** a `broken` bit clearing before edge K causes ISSUE at edge K and targets that station.
- **Other inputs:** `play_flag` is ignored outside IDLE. `timer_tick` in IDLE is ignored.
- **Reset mid-operation:** immediate return to reset values, asynchronously. `break_req` drops in the same cycle.

## Configuration
- **`STARSHIP_LEVEL_RAMP_EN` defined:** level counter and interval ramp as above.
- **Not defined:** `level` is tied to 0, no tick counter is built, and the interval is always `INTERVAL_INIT`.

## Test plan
- **First break, single free station:** Reset, `play_flag` pulse, `broken = 4'b0111`, 8 ticks. Required: exactly one `break_req = 4'b1000` pulse, one cycle after the 8th tick, and `random_hex` equal to model `lfsr[7:4]`.
- **Scan wrap:** Force `lfsr[1:0] = 3`, `broken = 4'b1000`. Required: `break_req = 4'b0001`.
- **All broken, then release:**
  - `broken = 4'hF` at expiry: no pulse for 20 cycles and `all_broken = 1`.
  - Clear `broken[2]`: `break_req = 4'b0100` on the next edge and `all_broken = 0`.
- **Level ramp (macro defined):**
  - After 32 ticks: `level = 1`, next interval 7.
  - After 192 ticks: `level = 6`, interval 2.
  - After 256 ticks: `level = 7`, interval still 2.
  - After 300 ticks: `level` remains 7.
- **Game over and reset:**
  - `gameover_ctrl` at `countdown = 3`: IDLE next edge, `level = 0`, no `break_req`.
  - `Reset` during ISSUE: `break_req = 0` the same cycle and `q_Idle = 1`.
- **Macro undefined:** 200 ticks with all stations repaired immediately. Required: `level = 0` throughout and a `break_req` every 8 ticks plus 1 cycle.
